// File: rtl/param_load_counter.sv
// Loadable up/down counter with configurable width/modulus, wrap or saturate, tc pulse and sticky ovf.
// Optional feature: define PLC_CAPTURE_EN to add the capture input and cap_val snapshot register.
module param_load_counter #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  MAX_VAL   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] data,
  input  logic             ovf_clr,
`ifdef PLC_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_val,
`endif
  output logic [WIDTH-1:0] cout,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;
  logic             at_top, at_bot;

  assign at_top = (cnt_reg == MAX_VAL);
  assign at_bot = (cnt_reg == ZERO);

  // Limits are checked before stepping, so the native WIDTH roll-over is never reached
  // when the modulus is smaller than the full range.
  always_comb begin
    cnt_next = cnt_reg;
    tc_next  = 1'b0;
    ovf_next = ovf_reg & ~ovf_clr;
    if (load) begin
      cnt_next = (data > MAX_VAL) ? MAX_VAL : data;
    end else if (enable) begin
      if (up_dn) begin
        if (at_top) begin
          cnt_next = sat_mode ? MAX_VAL : ZERO;
          tc_next  = 1'b1;
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + ONE;
        end
      end else begin
        if (at_bot) begin
          cnt_next = sat_mode ? ZERO : MAX_VAL;
          tc_next  = 1'b1;
          ovf_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= RESET_VAL;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
    end
  end

  assign cout = cnt_reg;
  assign tc   = tc_reg;
  assign ovf  = ovf_reg;

`ifdef PLC_CAPTURE_EN
  logic [WIDTH-1:0] cap_reg;

  // Snapshot is the pre-update count, i.e. what cout shows during the capture cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_reg <= RESET_VAL;
    end else if (capture) begin
      cap_reg <= cnt_reg;
    end
  end

  assign cap_val = cap_reg;
`endif

endmodule

// File: tb/tb_param_load_counter.sv
// Bench for param_load_counter: a full-range 8-bit instance and a MAX_VAL=9 instance,
// table-driven vectors checked through an expected-result queue.
module tb_param_load_counter;

  logic       clk = 1'b0;
  logic       rst_s [2];
  logic       ld_s  [2];
  logic       en_s  [2];
  logic       ud_s  [2];
  logic       sm_s  [2];
  logic       clr_s [2];
  logic [7:0] d_s   [2];
  logic [7:0] cout_w[2];
  logic       tc_w  [2];
  logic       ovf_w [2];
`ifdef PLC_CAPTURE_EN
  logic       cap_s [2];
  logic [7:0] capv_w[2];
`endif

  always #5 clk = ~clk;

  param_load_counter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst_s[0]), .load(ld_s[0]), .enable(en_s[0]), .up_dn(ud_s[0]),
    .sat_mode(sm_s[0]), .data(d_s[0]), .ovf_clr(clr_s[0]),
`ifdef PLC_CAPTURE_EN
    .capture(cap_s[0]), .cap_val(capv_w[0]),
`endif
    .cout(cout_w[0]), .tc(tc_w[0]), .ovf(ovf_w[0])
  );

  param_load_counter #(.WIDTH(8), .MAX_VAL(8'd9)) dut9 (
    .clk(clk), .reset(rst_s[1]), .load(ld_s[1]), .enable(en_s[1]), .up_dn(ud_s[1]),
    .sat_mode(sm_s[1]), .data(d_s[1]), .ovf_clr(clr_s[1]),
`ifdef PLC_CAPTURE_EN
    .capture(cap_s[1]), .cap_val(capv_w[1]),
`endif
    .cout(cout_w[1]), .tc(tc_w[1]), .ovf(ovf_w[1])
  );

  typedef struct {
    int         sel;
    logic       rst, ld, en, ud, sm, clr;
    logic [7:0] d;
    logic [7:0] e_cout;
    logic       e_tc, e_ovf;
  } vec_t;

  typedef struct {
    int         id;
    int         sel;
    logic [7:0] cout;
    logic       tc, ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(int sel, logic rst, logic ld, logic en, logic ud, logic sm,
                              logic clr, logic [7:0] d, logic [7:0] ec, logic et, logic eo);
    vec_t v;
    v.sel = sel; v.rst = rst; v.ld = ld; v.en = en; v.ud = ud; v.sm = sm; v.clr = clr;
    v.d = d; v.e_cout = ec; v.e_tc = et; v.e_ovf = eo;
    return v;
  endfunction

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      rst_s[i] = 1'b0; ld_s[i] = 1'b0; en_s[i] = 1'b0; ud_s[i] = 1'b0;
      sm_s[i] = 1'b0; clr_s[i] = 1'b0; d_s[i] = 8'h00;
`ifdef PLC_CAPTURE_EN
      cap_s[i] = 1'b0;
`endif
    end
  endtask

  // Drive one vector on the selected instance (the other one holds), then check one edge later.
  task automatic apply(input vec_t v, input int id);
    exp_t e, got;
    @(negedge clk);
    idle_inputs();
    rst_s[v.sel] = v.rst; ld_s[v.sel] = v.ld; en_s[v.sel] = v.en; ud_s[v.sel] = v.ud;
    sm_s[v.sel] = v.sm; clr_s[v.sel] = v.clr; d_s[v.sel] = v.d;
    e.id = id; e.sel = v.sel; e.cout = v.e_cout; e.tc = v.e_tc; e.ovf = v.e_ovf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    n_vec++;
    if (cout_w[got.sel] !== got.cout || tc_w[got.sel] !== got.tc || ovf_w[got.sel] !== got.ovf) begin
      n_bad++;
      $display("FAIL vec%0d dut%0d: got cout=%02h tc=%b ovf=%b, want cout=%02h tc=%b ovf=%b",
               got.id, got.sel, cout_w[got.sel], tc_w[got.sel], ovf_w[got.sel],
               got.cout, got.tc, got.ovf);
    end else begin
      $display("vec%0d dut%0d: cout=%02h tc=%b ovf=%b ok", got.id, got.sel,
               cout_w[got.sel], tc_w[got.sel], ovf_w[got.sel]);
    end
  endtask

`ifdef PLC_CAPTURE_EN
  task automatic chk_cap(input string nm, input logic [7:0] want);
    n_vec++;
    if (capv_w[0] !== want) begin
      n_bad++;
      $display("FAIL %s: got cap_val=%02h, want %02h", nm, capv_w[0], want);
    end else begin
      $display("%s: cap_val=%02h ok", nm, capv_w[0]);
    end
  endtask
`endif

  initial begin
    int id;
    vec_t v;
    idle_inputs();

    //          sel rst ld en ud sm clr data    cout   tc ovf
    // reset beats load; both instances
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 8'h55, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 8'h05, 8'h00, 0, 0));
    // wrap up past FF
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'hFE, 8'hFE, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h01, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0));
    // wrap down past 00
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 8'h00, 8'hFF, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 8'hFE, 0, 1));
    // saturate at both limits; load leaves ovf alone
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 8'h00, 8'hFF, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 8'h00, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 8'h00, 8'hFF, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 0, 8'h00, 8'h00, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h01, 0, 1));
    // load wins over enable, even at the limit
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'h10, 8'h10, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 8'hFF, 8'hFF, 0, 1));
    // reset mid-count and at the limit: no tc
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h7E, 8'h7E, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h7F, 0, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 1, 0, 0, 8'h00, 8'h00, 0, 0));
    // MAX_VAL=9: saturate, load clamp
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd8,   8'd8, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 8'd0,   8'd9, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 8'd0,   8'd9, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 1, 0, 8'd0,   8'd9, 1, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd200, 8'd9, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd9,   8'd9, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 8'd10,  8'd9, 0, 0));
    // MAX_VAL=9: wrap both ways, clear vs. new overflow
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 8'd0,   8'd0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd9, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0, 8'd0,   8'd0, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 1, 8'd0,   8'd9, 1, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 8'd0,   8'd9, 0, 0));
    tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 8'd0,   8'd8, 0, 0));

    id = 0;
    foreach (tbl[i]) begin
      apply(tbl[i], id);
      id++;
    end

    // tc is a single-cycle pulse: wrap once, then idle several cycles
    apply(mk(0, 0, 1, 0, 0, 0, 1, 8'hFF, 8'hFF, 0, 0), id++);
    apply(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h00, 1, 1), id++);
    for (int k = 0; k < 3; k++) apply(mk(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1), id++);

    // direction flips every cycle on the 9-modulus instance
    apply(mk(1, 0, 1, 0, 0, 0, 1, 8'd9, 8'd9, 0, 0), id++);
    apply(mk(1, 0, 0, 1, 1, 0, 0, 8'd0, 8'd0, 1, 1), id++);
    apply(mk(1, 0, 0, 1, 0, 0, 0, 8'd0, 8'd9, 1, 1), id++);
    apply(mk(1, 0, 0, 1, 0, 1, 0, 8'd0, 8'd8, 0, 1), id++);

`ifdef PLC_CAPTURE_EN
    apply(mk(0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0), id++);
    chk_cap("cap_reset", 8'h00);
    apply(mk(0, 0, 1, 0, 0, 0, 0, 8'h1F, 8'h1F, 0, 0), id++);
    apply(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h20, 0, 0), id++);
    chk_cap("cap_hold", 8'h00);
    v = mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h21, 0, 0);
    fork
      begin
        @(negedge clk);
        #1 cap_s[0] = 1'b1;
      end
    join_none
    apply(v, id++);
    chk_cap("cap_take", 8'h20);
    apply(mk(0, 0, 0, 1, 1, 0, 0, 8'h00, 8'h22, 0, 0), id++);
    chk_cap("cap_keep", 8'h20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
